// File: rtl/corelet_ctrl.sv
// corelet_ctrl -- sequencer for one 3x3 convolution tile on the corelet.
//
// Reads weight vectors (WS only) and activation vectors from xmem, and
// drives the corelet kernel-load/execute phases (inst_w) aligned with the
// xmem read data. Steps kij through every kernel position, then pulses
// readout_start to the SFU and finally pulses done. Control only: xmem Q
// feeds the corelet vector_data_in directly.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           one-cycle run request, sampled only in IDLE
//   is_os           output-stationary mode, latched with start
//   cen_xmem        xmem chip enable (active-low)
//   wen_xmem        xmem write enable (active-low), always 1
//   a_xmem          xmem address (11-bit, wraps mod 2048)
//   inst_w          {0, execute, kernel load}, one cycle after the address
//   kij             current kernel position
//   readout_start   one-cycle pulse to the SFU
//   busy            high from the cycle after an accepted start until done
//   done            one-cycle completion pulse
//
// gap may be 0; drain and ro_cycles must be at least 1.
module corelet_ctrl #(
  parameter int unsigned col       = 8,
  parameter int unsigned n_act     = 36,
  parameter int unsigned kij_num   = 9,
  parameter int unsigned w_base    = 1024,
  parameter int unsigned gap       = 10,
  parameter int unsigned drain     = 20,
  parameter int unsigned ro_cycles = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_os,
  output logic        cen_xmem,
  output logic        wen_xmem,
  output logic [10:0] a_xmem,
  output logic [2:0]  inst_w,
  output logic [3:0]  kij,
  output logic        readout_start,
  output logic        busy,
  output logic        done
);

  function automatic int unsigned cnt_width();
    int unsigned m;
    m = col;
    if (n_act > m)     m = n_act;
    if (gap > m)       m = gap;
    if (drain > m)     m = drain;
    if (ro_cycles > m) m = ro_cycles;
    if ($clog2(m + 1) > 7) return $clog2(m + 1);
    return 7;
  endfunction

  localparam int unsigned CW = cnt_width();

  localparam logic [CW-1:0] COL_LAST   = CW'(col - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(gap - 1);
  localparam logic [CW-1:0] NACT_LAST  = CW'(n_act - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(drain - 1);
  localparam logic [CW-1:0] RO_LAST    = CW'(ro_cycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_GAP,
    S_EXEC,
    S_DRAIN,
    S_READOUT,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            os_mode;
  logic            ph_w;     // address cycle of a kernel-load phase went out
  logic            ph_e;     // address cycle of an execute phase went out
  logic [10:0]     w_addr;

  // 11-bit arithmetic: the weight address wraps modulo 2048 by truncation.
  assign w_addr = 11'(w_base) + (11'(kij) * 11'(col)) + 11'(cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      kij           <= '0;
      os_mode       <= 1'b0;
      cen_xmem      <= 1'b1;
      wen_xmem      <= 1'b1;
      a_xmem        <= '0;
      ph_w          <= 1'b0;
      ph_e          <= 1'b0;
      inst_w        <= '0;
      readout_start <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      // Outputs are decoded from the state of the cycle just ending, so the
      // xmem address trails the state by one cycle and inst_w by two; inst_w
      // then lines up with the xmem read data.
      wen_xmem      <= 1'b1;
      cen_xmem      <= !(state == S_WLOAD || state == S_EXEC);
      ph_w          <= (state == S_WLOAD);
      ph_e          <= (state == S_EXEC);
      inst_w        <= {1'b0, ph_e, ph_w};
      readout_start <= (state == S_READOUT) && (cnt == '0);
      done          <= (state == S_DONE);
      if (state == S_WLOAD)     a_xmem <= w_addr;
      else if (state == S_EXEC) a_xmem <= 11'(cnt);

      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          kij <= '0;
          if (start) begin
            os_mode <= is_os;
            busy    <= 1'b1;
            state   <= is_os ? S_EXEC : S_WLOAD;
          end
        end
        S_WLOAD: begin
          if (cnt == COL_LAST) begin
            cnt   <= '0;
            state <= (gap == 0) ? S_EXEC : S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_EXEC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (cnt == NACT_LAST) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            cnt <= '0;
            if (32'(kij) < kij_num - 1) begin
              kij   <= kij + 1'b1;
              state <= os_mode ? S_EXEC : S_WLOAD;
            end else begin
              state <= S_READOUT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_READOUT: begin
          if (cnt == RO_LAST) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl. Two instances: the default configuration
// and a small wrap/boundary configuration (w_base=2040, kij_num=2, n_act=1).
// Every output is compared every cycle of a run against a timeline derived
// from the run's parameters and the offset from the start-sampling edge.
module tb_corelet_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic start, start2, is_os;

  logic        cen0, wen0, ro0, busy0, done0;
  logic [10:0] a0;
  logic [2:0]  inst0;
  logic [3:0]  kij0;
  logic        cen1, wen1, ro1, busy1, done1;
  logic [10:0] a1;
  logic [2:0]  inst1;
  logic [3:0]  kij1;

  always #5 clk = ~clk;

  corelet_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .is_os(is_os),
    .cen_xmem(cen0), .wen_xmem(wen0), .a_xmem(a0), .inst_w(inst0),
    .kij(kij0), .readout_start(ro0), .busy(busy0), .done(done0)
  );

  corelet_ctrl #(
    .col(8), .n_act(1), .kij_num(2), .w_base(2040),
    .gap(2), .drain(3), .ro_cycles(4)
  ) u_wrap (
    .clk(clk), .reset(reset), .start(start2), .is_os(is_os),
    .cen_xmem(cen1), .wen_xmem(wen1), .a_xmem(a1), .inst_w(inst1),
    .kij(kij1), .readout_start(ro1), .busy(busy1), .done(done1)
  );

  // Per-instance parameters: index 0 = u_dut, 1 = u_wrap.
  int pc  [2] = '{8, 8};
  int pn  [2] = '{36, 1};
  int pk  [2] = '{9, 2};
  int pwb [2] = '{1024, 2040};
  int pg  [2] = '{10, 2};
  int pd  [2] = '{20, 3};
  int pr  [2] = '{16, 4};

  // Address is ignored while the xmem is not enabled.
  logic [22:0] obs0, obs1, raw0, raw1;
  assign raw0 = {cen0, wen0, a0, inst0, kij0, ro0, busy0, done0};
  assign raw1 = {cen1, wen1, a1, inst1, kij1, ro1, busy1, done1};
  assign obs0 = {cen0, wen0, cen0 ? 11'd0 : a0, inst0, kij0, ro0, busy0, done0};
  assign obs1 = {cen1, wen1, cen1 ? 11'd0 : a1, inst1, kij1, ro1, busy1, done1};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Which xmem access (0 none, 1 weight, 2 activation) the address output
  // shows t edges after the start-sampling edge, and at what address.
  function automatic void phase(input int t, input int s, input bit os,
                                output int ph, output int addr);
    int per, u, k, p;
    per  = os ? pn[s] + pd[s] : pc[s] + pg[s] + pn[s] + pd[s];
    ph   = 0;
    addr = 0;
    if (t >= 1 && t <= pk[s] * per) begin
      u = t - 1;
      k = u / per;
      p = u % per;
      if (os) begin
        if (p < pn[s]) begin ph = 2; addr = p; end
      end else if (p < pc[s]) begin
        ph = 1; addr = pwb[s] + k * pc[s] + p;
      end else if (p >= pc[s] + pg[s] && p < pc[s] + pg[s] + pn[s]) begin
        ph = 2; addr = p - pc[s] - pg[s];
      end
    end
  endfunction

  function automatic logic [22:0] exp_word(input int t, input int s, input bit os);
    int per, ph, addr, php, addrp, k, ro_t, done_t;
    per    = os ? pn[s] + pd[s] : pc[s] + pg[s] + pn[s] + pd[s];
    ro_t   = pk[s] * per + 1;
    done_t = ro_t + pr[s];
    phase(t, s, os, ph, addr);
    phase(t - 1, s, os, php, addrp);
    k = t / per;
    if (k > pk[s] - 1) k = pk[s] - 1;
    if (t > done_t) k = 0;
    return {ph == 0, 1'b1, (ph == 0) ? 11'd0 : 11'(addr),
            1'b0, php == 2, php == 1, 4'(k),
            t == ro_t, t < done_t, t == done_t};
  endfunction

  // One tile run: start pulse, then a per-cycle trace check from t=0 (edge
  // E) until done plus tail cycles, or until stop_t. With rej set, start is
  // also pulsed during EXEC of kij 0 and during the DONE-state cycle.
  task automatic run(input int s, input bit os, input bit rej,
                     input int stop_t, input int tail);
    int per, last;
    per  = os ? pn[s] + pd[s] : pc[s] + pg[s] + pn[s] + pd[s];
    last = pk[s] * per + pr[s] + 1 + tail;
    is_os = os;
    if (s == 0) start = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
    is_os  = !os;
    for (int t = 0; t <= last; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("trace s%0d %s t%0d", s, os ? "os" : "ws", t),
            32'(s == 0 ? obs0 : obs1), 32'(exp_word(t, s, os)));
      start = rej && (t == 30 || t == pk[s] * per + pr[s]);
      if (t == stop_t) break;
    end
    start = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    is_os  = 1'b0;
    #12;
    check("reset dut",  32'(raw0), 32'h600000);
    check("reset wrap", 32'(raw1), 32'h600000);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // WS default run with starts during EXEC and DONE that must be ignored.
    run(0, 1'b0, 1'b1, -1, 3);
    // Back-to-back: second start lands in the cycle done is visible.
    run(0, 1'b0, 1'b0, -1, 0);
    run(0, 1'b0, 1'b0, -1, 3);
    // Output-stationary run; is_os is flipped after start to test latching.
    run(0, 1'b1, 1'b0, -1, 3);
    // Weight addresses of kij 1 wrap past 2047; one-cycle EXEC.
    run(1, 1'b0, 1'b0, -1, 3);

    // Reset in the middle of an EXEC phase at kij 4.
    run(0, 1'b0, 1'b0, 320, 0);
    #2 reset = 1'b1;
    #1 check("reset async", 32'(raw0), 32'h600000);
    @(posedge clk);
    #1 check("reset held", 32'(raw0), 32'h600000);
    reset = 1'b0;
    @(posedge clk);
    #1 check("idle after reset", 32'(raw0), 32'h600000);
    run(0, 1'b0, 1'b0, -1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/corelet_ctrl.md
# corelet_ctrl

Sequencer that sits directly upstream of the corelet and drives it through a full 3x3 convolution tile. It reads weight and activation vectors from the input SRAM (xmem) and issues `inst_w` kernel-load/execute phases aligned with the SRAM read data. It steps `kij` through all kernel positions and pulses `readout_start` once accumulation is finished. It generates control only; xmem Q feeds corelet `vector_data_in` directly.

## Interface
- `col`, 8, output columns = weight vectors loaded per kij
- `n_act`, 36, activation vectors streamed per kij (≥1)
- `kij_num`, 9, kernel positions per tile (1..16)
- `w_base`, 1024, xmem base address of weights
- `gap`, 10, idle cycles between kernel load and execute
- `drain`, 20, idle cycles after execute (mac array/ofifo/SFU flush)
- `ro_cycles`, 16, cycles reserved for SFU readout
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-high
- `start` in 1: one-cycle request to run a tile; sampled only in IDLE
- `is_os` in 1: output-stationary mode; sampled at start, held for the run
- `cen_xmem` out 1: xmem chip enable, active-low
- `wen_xmem` out 1: xmem write enable, active-low; constant 1 (read only)
- `a_xmem` out 11: xmem address
- `inst_w` out 3: bit1 execute, bit0 kernel load, bit2 always 0
- `kij` out 4: current kernel position, to corelet/SFU
- `readout_start` out 1: one-cycle pulse to SFU
- `busy` out 1: high from the cycle after an accepted start until DONE
- `done` out 1: one-cycle completion pulse

## Operation
- States: IDLE, WLOAD, GAP, EXEC, DRAIN, READOUT, DONE.
- IDLE:
  - `start`=1 → WLOAD, or → EXEC if `is_os`=1.
  - Clears `kij` and the phase counter `cnt`; latches `is_os`.
- WLOAD (`cnt`=0..col-1):
  - `cen_xmem`=0, `a_xmem`=w_base + kij*col + cnt.
  - After col cycles → GAP.
- GAP: `cen_xmem`=1 for `gap` cycles → EXEC.
- EXEC (`cnt`=0..n_act-1):
  - `cen_xmem`=0, `a_xmem`=cnt.
  - After n_act cycles → DRAIN.
- DRAIN: `drain` idle cycles, then:
  - if kij<kij_num-1: kij+1 → WLOAD (OS: → EXEC).
  - else → READOUT, asserting `readout_start` for exactly the first READOUT cycle.
- READOUT: `ro_cycles` cycles → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `inst_w` timing: `inst_w`[0]=1 exactly one cycle after each WLOAD address cycle; `inst_w`[1]=1 exactly one cycle after each EXEC address cycle. `inst_w` is a registered 1-cycle delay of the phase decode, aligning it with xmem Q.
- `kij` changes only on the DRAIN→WLOAD/EXEC transition. It stays at kij_num-1 through READOUT/DONE and returns to 0 in IDLE.
- `a_xmem` address arithmetic is 11-bit and wraps modulo 2048. No saturation.
- `start` is ignored outside IDLE. A `start` in the DONE cycle is ignored.
- Counters use ≥7 bits so that `cnt` never overflows for the parameter defaults.

## Timing
- All outputs are registered.
- Reset values: `cen_xmem`=1, `wen_xmem`=1, `a_xmem`=0, `inst_w`=0, `kij`=0, `readout_start`=0, `busy`=0, `done`=0. State resets to IDLE.
- Reset asserted mid-run returns to IDLE immediately (asynchronously), with no further xmem access.
- First WLOAD address appears at edge E+1, where E is the edge that samples `start`. The first `inst_w`[0] appears at E+2.
- Cycles per kij:
  - WS: col+gap+n_act+drain (defaults: 74).
  - OS: n_act+drain (defaults: 56).
- `readout_start` at edge E+1+kij_num*perkij. `done` follows ro_cycles cycles later.
- `inst_w` falls to 0 one cycle after the last address of each phase. The value 3'b011 is never driven.

## Test plan
- WS default run: `start` once → 9×(8 loads @1024+8k..1031+8k, 36 execs @0..35). Check:
  - `inst_w`=001 for 8 cycles and 010 for 36 cycles per kij, each lagging its address by 1 cycle.
  - `readout_start` exactly once, at E+667.
  - `done` 16 cycles later.
- OS run: `is_os`=1 → no WLOAD/GAP. 9×36 exec reads; `readout_start` at E+1+9×56.
- Start rejection: pulse `start` during EXEC and during DONE → no restart. `busy` is unaffected, and exactly one `done` is produced.
- Reset mid-EXEC at kij=4 → all outputs immediately at reset values. A new `start` replays from kij=0, address 1024.
- Wrap/boundary: w_base=2040, col=8, kij_num=2 → kij 1 addresses wrap to 0..7 mod 2048. With n_act=1, EXEC lasts exactly 1 cycle.
- Back-to-back: `start` in the first IDLE cycle after `done` → second run with identical address/`inst_w` trace shifted in time.
